// File: rtl/addsub_defs.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding, the subtract-path carry-in and the step-counter width helper.
package addsub_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's-complement subtract is A + ~B + 1, so the sub carry starts at one.
  localparam logic SUB_CIN = 1'b1;

  // Bit-step counter width; a single-bit operand still needs one counter bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder, shared by the add and subtract paths.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Captures A and B on an accepted start and
// produces A+B and A-B one bit per clock, LSB first. Results and carries
// are published together on the completion edge, flagged by a one-cycle
// done strobe.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds signed-overflow
// outputs add_ovf / sub_ovf.
module serial_addsub
  import addsub_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] sub_diff,
  output logic             adder_out,
  output logic             sub_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             add_ovf,
  output logic             sub_ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             ca_q, ca_d;
  logic             cs_q, cs_d;
  logic [WIDTH-1:0] acc_add_q, acc_add_d;
  logic [WIDTH-1:0] acc_sub_q, acc_sub_d;
  logic [WIDTH-1:0] add_sum_q, add_sum_d;
  logic [WIDTH-1:0] sub_diff_q, sub_diff_d;
  logic             adder_out_q, adder_out_d;
  logic             sub_out_q, sub_out_d;
  logic             add_ovf_q, add_ovf_d;
  logic             sub_ovf_q, sub_ovf_d;

  logic             add_bit_s, add_co_s;
  logic             sub_bit_s, sub_co_s;
  logic [WIDTH-1:0] acc_add_nx_s, acc_sub_nx_s;
  logic             last_s;

  full_adder_bit u_fa_add (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (ca_q),
    .s    (add_bit_s),
    .cout (add_co_s)
  );

  full_adder_bit u_fa_sub (
    .a    (a_sh_q[0]),
    .b    (~b_sh_q[0]),
    .cin  (cs_q),
    .s    (sub_bit_s),
    .cout (sub_co_s)
  );

  // New result bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
  generate
    if (WIDTH > 1) begin : g_acc_wide
      assign acc_add_nx_s = {add_bit_s, acc_add_q[WIDTH-1:1]};
      assign acc_sub_nx_s = {sub_bit_s, acc_sub_q[WIDTH-1:1]};
    end else begin : g_acc_one
      assign acc_add_nx_s = add_bit_s;
      assign acc_sub_nx_s = sub_bit_s;
    end
  endgenerate

  assign last_s = (cnt_q == CW'(WIDTH - 1));

  // Next-state logic: accept start in IDLE/DONE, step one bit per RUN cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    ca_d        = ca_q;
    cs_d        = cs_q;
    acc_add_d   = acc_add_q;
    acc_sub_d   = acc_sub_q;
    add_sum_d   = add_sum_q;
    sub_diff_d  = sub_diff_q;
    adder_out_d = adder_out_q;
    sub_out_d   = sub_out_q;
    add_ovf_d   = add_ovf_q;
    sub_ovf_d   = sub_ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          ca_d    = 1'b0;
          cs_d    = SUB_CIN;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        ca_d      = add_co_s;
        cs_d      = sub_co_s;
        acc_add_d = acc_add_nx_s;
        acc_sub_d = acc_sub_nx_s;
        if (last_s) begin
          // MSB step: publish everything together; overflow is carry-in ^ carry-out of the MSB.
          add_sum_d   = acc_add_nx_s;
          sub_diff_d  = acc_sub_nx_s;
          adder_out_d = add_co_s;
          sub_out_d   = sub_co_s;
          add_ovf_d   = ca_q ^ add_co_s;
          sub_ovf_d   = cs_q ^ sub_co_s;
          cnt_d       = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      ca_q        <= 1'b0;
      cs_q        <= 1'b0;
      acc_add_q   <= '0;
      acc_sub_q   <= '0;
      add_sum_q   <= '0;
      sub_diff_q  <= '0;
      adder_out_q <= 1'b0;
      sub_out_q   <= 1'b0;
      add_ovf_q   <= 1'b0;
      sub_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      ca_q        <= ca_d;
      cs_q        <= cs_d;
      acc_add_q   <= acc_add_d;
      acc_sub_q   <= acc_sub_d;
      add_sum_q   <= add_sum_d;
      sub_diff_q  <= sub_diff_d;
      adder_out_q <= adder_out_d;
      sub_out_q   <= sub_out_d;
      add_ovf_q   <= add_ovf_d;
      sub_ovf_q   <= sub_ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign add_sum   = add_sum_q;
  assign sub_diff  = sub_diff_q;
  assign adder_out = adder_out_q;
  assign sub_out   = sub_out_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  assign add_ovf = add_ovf_q;
  assign sub_ovf = sub_ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed vector table,
// multi-cycle corner sequences and randomized operands against an
// arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_s, b_s;
  logic         busy, done;
  logic [W-1:0] add_sum, sub_diff;
  logic         adder_out, sub_out;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         add_ovf, sub_ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a_s),
    .b         (b_s),
    .busy      (busy),
    .done      (done),
    .add_sum   (add_sum),
    .sub_diff  (sub_diff),
    .adder_out (adder_out),
    .sub_out   (sub_out)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .add_ovf   (add_ovf),
    .sub_ovf   (sub_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         co;
    logic [W-1:0] diff;
    logic         so;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic [W-1:0] diff;
    logic         so;
    logic         aovf;
    logic         sovf;
  } res_t;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int ua, ub, sa, sb, ssum, sdif;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r.sum  = W'((ua + ub) % 256);
    r.co   = (ua + ub) >= 256;
    r.diff = W'((ua - ub + 256) % 256);
    r.so   = (ua >= ub);
    ssum   = sa + sb;
    sdif   = sa - sb;
    r.aovf = (ssum > 127) || (ssum < -128);
    r.sovf = (sdif > 127) || (sdif < -128);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; lat counts edges from the accept edge (inclusive) to done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    start = 1'b1;
    a_s   = a;
    b_s   = b;
    tick();
    start = 1'b0;
    a_s   = W'($urandom);
    b_s   = W'($urandom);
    lat   = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, ".add_sum"},   64'(add_sum),   64'(e.sum));
    check({tag, ".adder_out"}, 64'(adder_out), 64'(e.co));
    check({tag, ".sub_diff"},  64'(sub_diff),  64'(e.diff));
    check({tag, ".sub_out"},   64'(sub_out),   64'(e.so));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, ".add_ovf"},   64'(add_ovf),   64'(e.aovf));
    check({tag, ".sub_ovf"},   64'(sub_ovf),   64'(e.sovf));
`endif
  endtask

  vec_t vecs[7];
  res_t e, e1, e2;
  int   lat, ndone, gap;
  logic [W-1:0] ra, rb;

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1, 8'hFE, 1'b1};
    vecs[1] = '{8'h05, 8'h07, 8'h0C, 1'b0, 8'hFE, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0, 8'h7E, 1'b1};
    vecs[6] = '{8'h3C, 8'hA5, 8'hE1, 1'b0, 8'h97, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a_s   = '0;
    b_s   = '0;
    tick();
    tick();
    check("reset.busy",    64'(busy),     64'(0));
    check("reset.done",    64'(done),     64'(0));
    check("reset.add_sum", 64'(add_sum),  64'(0));
    check("reset.sub_diff",64'(sub_diff), 64'(0));
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      check("vec.latency",   64'(lat),       64'(W + 1));
      check("vec.busy_low",  64'(busy),      64'(0));
      check("vec.add_sum",   64'(add_sum),   64'(vecs[i].sum));
      check("vec.adder_out", 64'(adder_out), 64'(vecs[i].co));
      check("vec.sub_diff",  64'(sub_diff),  64'(vecs[i].diff));
      check("vec.sub_out",   64'(sub_out),   64'(vecs[i].so));
      tick();
      check("vec.done_pulse", 64'(done), 64'(0));
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    do_op(8'h7F, 8'h01, lat);
    check("ovf.add_ovf_7F_01", 64'(add_ovf), 64'(1));
    tick();
    do_op(8'h80, 8'h01, lat);
    check("ovf.sub_ovf_80_01", 64'(sub_ovf), 64'(1));
    tick();
`endif

    // Back-to-back with start held high
    start = 1'b1;
    a_s   = 8'hFF;
    b_s   = 8'h01;
    tick();
    a_s = 8'h80;
    b_s = 8'h80;
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("b2b.first_latency", 64'(lat), 64'(W + 1));
    e1 = model(8'hFF, 8'h01);
    check_res("b2b.first", e1);
    gap = 0;
    tick();
    gap++;
    check("b2b.busy_after_done", 64'(busy), 64'(1));
    while (!done && gap < 30) begin
      check("b2b.stable_sum",  64'(add_sum),  64'(e1.sum));
      check("b2b.stable_diff", 64'(sub_diff), 64'(e1.diff));
      tick();
      gap++;
    end
    start = 1'b0;
    check("b2b.period", 64'(gap), 64'(W + 1));
    check("b2b.second.add_sum",   64'(add_sum),   64'(8'h00));
    check("b2b.second.adder_out", 64'(adder_out), 64'(1));
    check("b2b.second.sub_diff",  64'(sub_diff),  64'(8'h00));
    check("b2b.second.sub_out",   64'(sub_out),   64'(1));
    tick();
    tick();

    // start pulsed during RUN is ignored
    e1 = model(8'h12, 8'h34);
    e2 = model(8'h05, 8'h07);
    start = 1'b1;
    a_s   = 8'h12;
    b_s   = 8'h34;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a_s   = 8'hAA;
    b_s   = 8'h55;
    tick();
    start = 1'b0;
    check("ign.busy", 64'(busy), 64'(1));
    check("ign.old_sum_held", 64'(add_sum), 64'(8'h00));
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) begin
        ndone++;
        check_res("ign.result", e1);
      end
      tick();
    end
    check("ign.done_count", 64'(ndone), 64'(1));

    // Randomized operands vs model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      e  = model(ra, rb);
      do_op(ra, rb, lat);
      check("rand.latency", 64'(lat), 64'(W + 1));
      check_res("rand", e);
      if (($urandom % 2) == 0) tick();
    end

    // Reset mid-RUN abandons the operation
    do_op(8'hFF, 8'hFF, lat);
    start = 1'b1;
    a_s   = 8'h33;
    b_s   = 8'h11;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rstrun.busy",      64'(busy),      64'(0));
    check("rstrun.done",      64'(done),      64'(0));
    check("rstrun.add_sum",   64'(add_sum),   64'(0));
    check("rstrun.sub_diff",  64'(sub_diff),  64'(0));
    check("rstrun.adder_out", 64'(adder_out), 64'(0));
    check("rstrun.sub_out",   64'(sub_out),   64'(0));
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) ndone++;
    end
    check("rstrun.no_done_after", 64'(ndone), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
